// File: rtl/random_seed_pio_sequencer.sv
// Random-seed PIO sequencer: arbitrates two seed producers, writes the winning
// seed into the PIO data register, reads it back to verify, retries on a
// mismatch, then releases the requester with a one-cycle ready pulse.
`timescale 1ns/1ps
module random_seed_pio_sequencer #(
    parameter int         DATA_W    = 32,
    parameter logic [1:0] SEED_ADDR = 2'd0,
    parameter int         MAX_RETRY = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_seed,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_seed,
    output logic              req1_ready,
    output logic [1:0]        avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    output logic              busy,
    output logic              done_pulse,
    output logic              error_pulse,
    output logic              last_owner
);

    localparam logic [2:0] MAX_RETRY_C = 3'(MAX_RETRY);

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

    state_t              state;
    logic                rr_ptr;
    logic                owner_q;
    logic [2:0]          retry_cnt;
    logic [DATA_W-1:0]   seed_q;

    logic                grant_any;
    logic                grant_idx;
    logic [DATA_W-1:0]   grant_seed;
    logic                rd_match;

    // The seed register is the only PIO register this block ever touches
    assign avm_address = SEED_ADDR;

    // Round-robin grant: the pointer only matters when both producers ask at once
    always_comb begin
        grant_any  = req0_valid | req1_valid;
        grant_idx  = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
        grant_seed = grant_idx ? req1_seed : req0_seed;
        rd_match   = (avm_readdata == seed_q);
    end

    // Sequencer FSM; every output is registered alongside the state it belongs to
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            rr_ptr         <= 1'b0;
            owner_q        <= 1'b0;
            retry_cnt      <= '0;
            seed_q         <= '0;
            req0_ready     <= 1'b0;
            req1_ready     <= 1'b0;
            done_pulse     <= 1'b0;
            error_pulse    <= 1'b0;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_writedata  <= '0;
            busy           <= 1'b0;
            last_owner     <= 1'b0;
        end else begin
            req0_ready  <= 1'b0;
            req1_ready  <= 1'b0;
            done_pulse  <= 1'b0;
            error_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        // Seed and owner are frozen here for the whole transaction
                        seed_q         <= grant_seed;
                        owner_q        <= grant_idx;
                        retry_cnt      <= '0;
                        avm_chipselect <= 1'b1;
                        avm_write_n    <= 1'b0;
                        avm_writedata  <= grant_seed;
                        busy           <= 1'b1;
                        state          <= WRITE;
                    end
                end
                WRITE: begin
                    avm_write_n <= 1'b1;
                    state       <= READ;
                end
                READ: begin
                    if (!rd_match && (retry_cnt < MAX_RETRY_C)) begin
                        retry_cnt   <= retry_cnt + 3'd1;
                        avm_write_n <= 1'b0;
                        state       <= WRITE;
                    end else begin
                        // Requester is released whether or not the seed verified
                        avm_chipselect <= 1'b0;
                        req0_ready     <= ~owner_q;
                        req1_ready     <= owner_q;
                        done_pulse     <= rd_match;
                        error_pulse    <= ~rd_match;
                        last_owner     <= owner_q;
                        rr_ptr         <= ~owner_q;
                        state          <= RESP;
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    avm_chipselect <= 1'b0;
                    avm_write_n    <= 1'b1;
                    busy           <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_random_seed_pio_sequencer.sv
// Directed bench for random_seed_pio_sequencer with a behavioural PIO model
// whose readback can be corrupted for a number of reads or stuck at all-ones.
`timescale 1ns/1ps
module tb_random_seed_pio_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid;
    logic [31:0] req0_seed;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_seed;
    logic        req1_ready;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        busy;
    logic        done_pulse;
    logic        error_pulse;
    logic        last_owner;

    int checks   = 0;
    int failures = 0;

    // PIO model state
    logic [31:0] pio_reg = 32'h0;
    int          corrupt_left = 0;
    logic        stuck = 1'b0;

    // Observation record filled by watch()
    int          wr_beats, r0_cyc, r1_cyc, done_cyc, err_cyc, done_cnt, err_cnt, resp_cnt;
    logic [31:0] wlog [8];

    random_seed_pio_sequencer #(
        .DATA_W(32), .SEED_ADDR(2'd0), .MAX_RETRY(3)
    ) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_seed(req0_seed), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_seed(req1_seed), .req1_ready(req1_ready),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect),
        .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata), .busy(busy), .done_pulse(done_pulse),
        .error_pulse(error_pulse), .last_owner(last_owner)
    );

    always #5 clk = ~clk;

    // PIO data register with optional readback corruption
    assign avm_readdata = stuck ? 32'hFFFF_FFFF : ((corrupt_left > 0) ? 32'h0 : pio_reg);

    always @(posedge clk) begin
        if (avm_chipselect && !avm_write_n && avm_address == 2'd0)
            pio_reg <= avm_writedata;
        if (avm_chipselect && avm_write_n && corrupt_left > 0)
            corrupt_left <= corrupt_left - 1;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        wr_beats = 0; r0_cyc = -1; r1_cyc = -1; done_cyc = -1; err_cyc = -1;
        done_cnt = 0; err_cnt = 0; resp_cnt = 0;
        for (int i = 0; i < 8; i++) wlog[i] = 32'h0;
    endtask

    // Step cycles first..last, logging PIO writes and pulses; requesters drop on ready
    task automatic watch(input int first, input int last);
        for (int c = first; c <= last; c++) begin
            step();
            if (avm_chipselect && !avm_write_n) begin
                if (wr_beats < 8) wlog[wr_beats] = avm_writedata;
                wr_beats++;
            end
            if (req0_ready) begin r0_cyc = c; resp_cnt++; req0_valid = 1'b0; end
            if (req1_ready) begin r1_cyc = c; resp_cnt++; req1_valid = 1'b0; end
            if (done_pulse) begin done_cyc = c; done_cnt++; end
            if (error_pulse) begin err_cyc = c; err_cnt++; end
        end
    endtask

    initial begin
        reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        req0_seed = 32'h0; req1_seed = 32'h0;
        step(); step();

        // Reset state
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cs", 64'(avm_chipselect), 64'd0);
        chk("rst_wn", 64'(avm_write_n), 64'd1);
        chk("rst_addr", 64'(avm_address), 64'd0);
        chk("rst_wdata", 64'(avm_writedata), 64'd0);
        chk("rst_pulses", 64'({req0_ready, req1_ready, done_pulse, error_pulse}), 64'd0);
        chk("rst_owner", 64'(last_owner), 64'd0);

        // Single req0 transaction, cycle by cycle
        reset = 1'b0; req0_valid = 1'b1; req0_seed = 32'hDEADBEEF;
        step();
        chk("t1_c1_write", 64'({avm_chipselect, avm_write_n, busy}), 64'b101);
        chk("t1_c1_wdata", 64'(avm_writedata), 64'hDEADBEEF);
        step();
        chk("t1_c2_read", 64'({avm_chipselect, avm_write_n, req0_ready}), 64'b110);
        step();
        chk("t1_c3_ready_done", 64'({req0_ready, done_pulse, error_pulse}), 64'b110);
        chk("t1_c3_cs_off", 64'(avm_chipselect), 64'd0);
        chk("t1_c3_owner", 64'(last_owner), 64'd0);
        chk("t1_pio", 64'(pio_reg), 64'hDEADBEEF);
        req0_valid = 1'b0;
        step();
        chk("t1_c4_idle", 64'({busy, req0_ready, done_pulse}), 64'd0);

        // Both valid: req0 wins first, req1 next
        reset = 1'b1; step(); reset = 1'b0;
        clear_obs();
        req0_valid = 1'b1; req0_seed = 32'h11111111;
        req1_valid = 1'b1; req1_seed = 32'h22222222;
        watch(1, 10);
        chk("t2_resp_cnt", 64'(resp_cnt), 64'd2);
        chk("t2_beats", 64'(wr_beats), 64'd2);
        chk("t2_w0", 64'(wlog[0]), 64'h11111111);
        chk("t2_w1", 64'(wlog[1]), 64'h22222222);
        chk("t2_r0_cyc", 64'(r0_cyc), 64'd3);
        chk("t2_r1_cyc", 64'(r1_cyc), 64'd7);
        chk("t2_owner", 64'(last_owner), 64'd1);
        chk("t2_idle", 64'(busy), 64'd0);

        // Two corrupted readbacks, then correct
        clear_obs();
        corrupt_left = 2;
        req0_valid = 1'b1; req0_seed = 32'hCAFEF00D;
        watch(1, 10);
        chk("t3_resp_cnt", 64'(resp_cnt), 64'd1);
        chk("t3_beats", 64'(wr_beats), 64'd3);
        chk("t3_done_cyc", 64'(done_cyc), 64'd7);
        chk("t3_r0_cyc", 64'(r0_cyc), 64'd7);
        chk("t3_err_cnt", 64'(err_cnt), 64'd0);
        chk("t3_pio", 64'(pio_reg), 64'hCAFEF00D);

        // Readback stuck high: all retries exhausted
        clear_obs();
        stuck = 1'b1;
        req1_valid = 1'b1; req1_seed = 32'h12345678;
        watch(1, 12);
        stuck = 1'b0;
        chk("t4_resp_cnt", 64'(resp_cnt), 64'd1);
        chk("t4_beats", 64'(wr_beats), 64'd4);
        chk("t4_err_cyc", 64'(err_cyc), 64'd9);
        chk("t4_r1_cyc", 64'(r1_cyc), 64'd9);
        chk("t4_done_cnt", 64'(done_cnt), 64'd0);
        chk("t4_owner", 64'(last_owner), 64'd1);
        chk("t4_idle", 64'(busy), 64'd0);

        // Reset during READ aborts silently; fresh request then completes
        req0_valid = 1'b1; req0_seed = 32'h0F0F0F0F;
        step();
        step();
        chk("t5_in_read", 64'({avm_chipselect, avm_write_n}), 64'b11);
        reset = 1'b1;
        step();
        chk("t5_abort_busy_cs", 64'({busy, avm_chipselect}), 64'd0);
        chk("t5_abort_pulses", 64'({req0_ready, req1_ready, done_pulse, error_pulse}), 64'd0);
        chk("t5_pio_kept", 64'(pio_reg), 64'h0F0F0F0F);
        reset = 1'b0; req0_seed = 32'h13579BDF;
        clear_obs();
        watch(1, 6);
        chk("t5_r0_cyc", 64'(r0_cyc), 64'd3);
        chk("t5_done_cyc", 64'(done_cyc), 64'd3);
        chk("t5_beats", 64'(wr_beats), 64'd1);
        chk("t5_pio", 64'(pio_reg), 64'h13579BDF);

        // req1 seed changes during WRITE: frozen seed still written and verified
        clear_obs();
        req1_valid = 1'b1; req1_seed = 32'hAAAA0000;
        step();
        chk("t6_c1_wdata", 64'(avm_writedata), 64'hAAAA0000);
        req1_seed = 32'h5555FFFF;
        watch(2, 8);
        chk("t6_r1_cyc", 64'(r1_cyc), 64'd3);
        chk("t6_done_cnt", 64'(done_cnt), 64'd1);
        chk("t6_err_cnt", 64'(err_cnt), 64'd0);
        chk("t6_pio", 64'(pio_reg), 64'hAAAA0000);
        chk("t6_owner", 64'(last_owner), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
